// File: rtl/wishbone_p2p_arbiter.sv
// Purpose: round-robin arbiter sharing one Wishbone p2p slave among NUM_MASTERS masters.
// Latency: grant one clk after first m_cyc; slave-side and response paths are combinational.
// Backpressure: losers hold m_cyc and wait un-terminated; owner keeps the bus while cyc|lock.
//
// Ports: clk/rst (sync, active-high); m_* flattened master-side buses (master i at
// slice [i*W +: W]); s_* single slave-side bus; gnt one-hot registered grant (0 when idle).
// Optional build macro WB_ARB_TIMEOUT_EN adds TIMEOUT_CYCLES and a sticky 'timeout' output;
// a stalled strobe is then terminated with m_err to the owner.
module wishbone_p2p_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
`ifdef WB_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS-1:0]            m_lock,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*8-1:0]          m_sel,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [NUM_MASTERS-1:0]            m_rty,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic                              s_lock,
    output logic [ADDR_WIDTH-1:0]             s_adr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [7:0]                        s_sel,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_ack,
    input  logic                              s_err,
    input  logic                              s_rty,
    output logic [NUM_MASTERS-1:0]            gnt
`ifdef WB_ARB_TIMEOUT_EN
    , output logic                            timeout
`endif
);

    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last_owner;
    logic [OW-1:0] nxt_owner;
    logic          nxt_found;
    logic          busy;
    logic          tout_fire;

    // Unpack the flattened master buses so the owner mux is a plain array index.
    logic [ADDR_WIDTH-1:0] adr_arr   [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];
    logic [7:0]            sel_arr   [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign adr_arr[g]   = m_adr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign sel_arr[g]   = m_sel[g*8 +: 8];
    end

    // Scan requesters starting just after the previous owner; the previous owner
    // itself is checked last, which gives the round-robin fairness bound.
    always_comb begin
        int idx;
        idx       = 0;
        nxt_found = 1'b0;
        nxt_owner = last_owner;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(last_owner) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!nxt_found && m_cyc[OW'(idx)]) begin
                nxt_found = 1'b1;
                nxt_owner = OW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= OW'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (nxt_found) begin
                        owner <= nxt_owner;
                        gnt   <= NUM_MASTERS'(1) << nxt_owner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Lock keeps ownership across gaps in cyc; release needs both low.
                    if (!(m_cyc[owner] | m_lock[owner])) begin
                        last_owner <= owner;
                        gnt        <= '0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

    assign s_cyc   = busy & m_cyc[owner];
    assign s_stb   = busy & m_stb[owner] & ~tout_fire;
    assign s_we    = busy & m_we[owner];
    assign s_lock  = busy & m_lock[owner];
    assign s_adr   = busy ? adr_arr[owner]   : '0;
    assign s_wdata = busy ? wdata_arr[owner] : '0;
    assign s_sel   = busy ? sel_arr[owner]   : '0;

    assign m_rdata = s_rdata;
    assign m_ack   = gnt & m_cyc & {NUM_MASTERS{s_ack}};
    assign m_err   = gnt & m_cyc & {NUM_MASTERS{s_err | tout_fire}};
    assign m_rty   = gnt & m_cyc & {NUM_MASTERS{s_rty}};

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tout_cnt;
    logic          stall;

    assign stall     = s_cyc & s_stb & ~(s_ack | s_err | s_rty);
    // The firing cycle acts as the termination: stb is withheld and the counter restarts.
    assign tout_fire = busy && (tout_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            tout_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (!busy || tout_fire || s_ack || s_err || s_rty) begin
                tout_cnt <= '0;
            end else if (stall) begin
                tout_cnt <= tout_cnt + 1'b1;
            end
            if (tout_fire) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign tout_fire = 1'b0;
`endif

endmodule
